// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - byte-wide instruction memory read port between fetch (master) and memory (slave)
interface inst_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i;
    logic [7:0]        mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_gnt_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_gnt_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - IF stage: PC owner, four-byte instruction fetch, redirect and stall handling
module inst_fetch #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    inst_fetch_if.master      mem,
    output logic              get_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_inst
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        req_cnt_q, req_cnt_d;
    logic [2:0]        rsp_cnt_q, rsp_cnt_d;
    logic              inflight_q, inflight_d;
    logic [31:0]       buf_q, buf_d;
    logic              get_inst_q, get_inst_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [31:0]       if_inst_q, if_inst_d;

    logic              mem_req;
    logic              mem_fire;
    logic [31:0]       buf_next;

    // Only stall[0] belongs to this stage; the rest of the vector is for later stages.
    logic              unused_stall;
    assign unused_stall = ^stall[5:1];

    always_comb begin
        mem_req    = 1'b0;
        mem_fire   = 1'b0;
        buf_next   = buf_q;
        state_d    = state_q;
        pc_d       = pc_q;
        req_cnt_d  = req_cnt_q;
        rsp_cnt_d  = rsp_cnt_q;
        inflight_d = inflight_q;
        buf_d      = buf_q;
        get_inst_d = get_inst_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;

        // Gating with the redirect guarantees no grant lands on a PC about to be abandoned.
        mem_req  = ~rst & (state_q == S_FETCH) & (req_cnt_q < 3'd4) & ~branch_flag_i;
        mem_fire = mem_req & mem.mem_gnt_i;

        // Returning byte merged in little-endian position; used for both the buffer and
        // the presented instruction so the 4th byte needs no extra cycle.
        buf_next[{rsp_cnt_q[1:0], 3'b000} +: 8] = mem.mem_rdata_i;

        if (branch_flag_i) begin
            // Clearing inflight drops any byte still returning for the old PC.
            pc_d       = branch_target_i;
            state_d    = S_FETCH;
            req_cnt_d  = 3'd0;
            rsp_cnt_d  = 3'd0;
            inflight_d = 1'b0;
            get_inst_d = 1'b0;
        end else if (state_q == S_FETCH) begin
            inflight_d = mem_fire;
            if (mem_fire) begin
                req_cnt_d = req_cnt_q + 3'd1;
            end
            if (inflight_q) begin
                buf_d     = buf_next;
                rsp_cnt_d = rsp_cnt_q + 3'd1;
                if (rsp_cnt_q == 3'd3) begin
                    if_inst_d  = buf_next;
                    if_pc_d    = pc_q;
                    get_inst_d = 1'b1;
                    state_d    = S_HOLD;
                end
            end
        end else if (!stall[0]) begin
            get_inst_d = 1'b0;
            pc_d       = pc_q + ADDR_W'(4);
            req_cnt_d  = 3'd0;
            rsp_cnt_d  = 3'd0;
            inflight_d = 1'b0;
            state_d    = S_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            req_cnt_q  <= 3'd0;
            rsp_cnt_q  <= 3'd0;
            inflight_q <= 1'b0;
            buf_q      <= 32'd0;
            get_inst_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_cnt_q  <= req_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            inflight_q <= inflight_d;
            buf_q      <= buf_d;
            get_inst_q <= get_inst_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    assign mem.mem_req_o  = mem_req;
    assign mem.mem_addr_o = pc_q + ADDR_W'(req_cnt_q);
    assign get_inst       = get_inst_q;
    assign if_pc          = if_pc_q;
    assign if_inst        = if_inst_q;

endmodule
